// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage FSM encoding and PC increment shared across the CPU front end.
package cpu_pkg;
   typedef enum logic [1:0] {START, REQ, WAIT, HOLD} fetch_state_t;
   localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: single-entry instruction register for decode, plus one side slot
// that parks a response arriving while the main entry is still occupied.
module fetch_buffer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             nreset,
   input  logic             flush,
   input  logic             load,
   input  logic             park,
   input  logic             drain,
   input  logic             consume,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] pc,
   output logic             valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc
);
   logic [WIDTH-1:0] side_inst, side_pc;
   // A flush only drops validity; stale side data is never drained because the FSM leaves HOLD.
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) begin
         valid     <= 1'b0;
         inst      <= '0;
         inst_pc   <= '0;
         side_inst <= '0;
         side_pc   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid   <= 1'b1;
         inst    <= data;
         inst_pc <= pc;
      end else if (drain) begin
         valid   <= 1'b1;
         inst    <= side_inst;
         inst_pc <= side_pc;
      end else begin
         if (park) begin
            side_inst <= data;
            side_pc   <= pc;
         end
         if (consume) valid <= 1'b0;
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding-request instruction fetch with redirect and decode buffer.
// FETCH_MISALIGN_EN adds a sticky fetch_fault that parks fetch on a misaligned redirect.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             nreset,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc
`ifdef FETCH_MISALIGN_EN
   ,
   output logic             fetch_fault
`endif
);
   fetch_state_t     state, state_nxt;
   logic [WIDTH-1:0] pc, pc_nxt, req_pc, target;
   logic             kill, kill_nxt, fault, misalign, redir;
   logic             accept, consume, load, park, drain;
`ifdef FETCH_MISALIGN_EN
   assign redir       = redirect && state != START && !fault;
   assign misalign    = redir && |redirect_pc[1:0];
   assign target      = redirect_pc;
   assign fetch_fault = fault;
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) fault <= 1'b0;
      else if (misalign) fault <= 1'b1;
`else
   assign redir    = redirect && state != START;
   assign misalign = 1'b0;
   assign fault    = 1'b0;
   assign target   = redirect_pc & ~WIDTH'(3);
`endif
   assign imem_req  = state == REQ && !redirect && !fault;
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign consume   = inst_valid && inst_ready;
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      kill_nxt  = kill;
      load      = 1'b0;
      park      = 1'b0;
      drain     = 1'b0;
      case (state)
         START: state_nxt = REQ;
         REQ:
            if (accept) begin
               state_nxt = WAIT;
               pc_nxt    = pc + WIDTH'(PC_STEP);
            end
         WAIT:
            if (imem_rvalid) begin
               kill_nxt  = 1'b0;
               state_nxt = REQ;
               load      = !kill && (!inst_valid || inst_ready);
               park      = !kill && inst_valid && !inst_ready;
               if (park) state_nxt = HOLD;
            end
         HOLD:
            if (!inst_valid || inst_ready) begin
               drain     = 1'b1;
               state_nxt = REQ;
            end
      endcase
      // Redirect overrides everything; an in-flight response with no rvalid yet must be killed.
      if (redir) begin
         pc_nxt    = target;
         kill_nxt  = state == WAIT && !imem_rvalid && !misalign;
         state_nxt = kill_nxt ? WAIT : REQ;
      end
   end
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) begin
         state  <= START;
         pc     <= RESET_PC;
         req_pc <= '0;
         kill   <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
         if (accept) req_pc <= pc;
      end
   fetch_buffer #(.WIDTH(WIDTH)) u_buf (
      .clock   (clock),
      .nreset  (nreset),
      .flush   (redir),
      .load    (load),
      .park    (park),
      .drain   (drain),
      .consume (consume),
      .data    (imem_rdata),
      .pc      (req_pc),
      .valid   (inst_valid),
      .inst    (inst),
      .inst_pc (inst_pc)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected fetch PCs are queued on accept, popped on decode transfer.
module tb_fetch_unit;
   import cpu_pkg::*;
   localparam logic [31:0] MASK = 32'hA5A5_0000;
   logic        clock = 1'b0, nreset = 1'b0;
   logic        imem_req, imem_ready = 1'b1, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        inst_valid, inst_ready = 1'b1;
   logic [31:0] inst, inst_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_EN
   logic        fetch_fault;
`endif
   int          checks = 0, failures = 0, delivered = 0, reqs = 0, lat = 1, cnt = 0, d0 = 0;
   logic        acc = 1'b0, pend = 1'b0, parked = 1'b0;
   logic [31:0] acc_addr = '0, paddr = '0, exp_pc = '0, exp_item;
   logic [31:0] sb[$];

   fetch_unit dut (
      .clock       (clock),
      .nreset      (nreset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_EN
      ,
      .fetch_fault (fetch_fault)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!acc && n < 40);
      if (!acc) check(tag, 32'(acc), 1);
   endtask

   task automatic wait_deliv(input string tag, input int target);
      int n = 0;
      while (delivered < target && n < 40) begin
         step();
         n++;
      end
      if (delivered < target) check(tag, delivered, target);
   endtask

   // Memory: accepts every request, answers lat cycles after accept with addr^MASK.
   always @(posedge clock) begin
      #1;
      imem_rvalid = 1'b0;
      if (!nreset) pend = 1'b0;
      else begin
         if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = acc_addr;
         end
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = paddr ^ MASK;
               pend        = 1'b0;
            end
         end
      end
   end

   // Monitor: PC model, request-address checks and in-order delivery scoreboard.
   always @(negedge clock) begin
      if (!nreset) begin
         acc    = 1'b0;
         reqs   = 0;
         parked = 1'b0;
         exp_pc = '0;
         sb.delete();
      end else begin
         if (inst_valid && inst_ready) begin
            delivered++;
            if (sb.size() == 0) check("sb_depth", 32'(sb.size()), 1);
            else begin
               exp_item = sb.pop_front();
               check("inst_pc", inst_pc, exp_item);
               check("inst", inst, exp_item ^ MASK);
            end
         end
         if (parked) check("parked_req", 32'(imem_req), 0);
         if (imem_req) check("imem_addr", imem_addr, exp_pc);
         acc      = imem_req && imem_ready;
         acc_addr = imem_addr;
         if (acc) begin
            sb.push_back(exp_pc);
            exp_pc += 32'd4;
            reqs++;
         end
         if (redirect && !parked) begin
            sb.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
            parked = |redirect_pc[1:0];
`endif
         end
      end
   end

   initial begin
      repeat (2) step();
      check("rst_req", 32'(imem_req), 0);
      check("rst_valid", 32'(inst_valid), 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      nreset = 1'b1;
      #1;
      check("start_req", 32'(imem_req), 0);
      step();
      step();
      check("valid_t2", 32'(inst_valid), 0);
      step();
      check("valid_t3", 32'(inst_valid), 1);
      check("first_pc", inst_pc, 0);
      wait_deliv("deliv_first3", 3);
      // Mid-transaction reset, then stall decode from the start.
      nreset     = 1'b0;
      inst_ready = 1'b0;
      repeat (2) step();
      nreset = 1'b1;
      repeat (9) step();
      check("hold_state", 32'(dut.state), 32'(HOLD));
      check("hold_reqs", reqs, 2);
      check("hold_req", 32'(imem_req), 0);
      check("hold_pc", inst_pc, 0);
      d0         = delivered;
      inst_ready = 1'b1;
      wait_deliv("deliv_hold", d0 + 2);
      // Redirect in WAIT, response two cycles later.
      lat = 3;
      wait_accept("acc_kill_a");
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      check("kill_set", 32'(dut.kill), 1);
      wait_accept("acc_kill_b");
      check("kill_target", acc_addr, 32'h0000_0100);
      d0 = delivered;
      wait_deliv("deliv_kill", d0 + 1);
      // Redirect coinciding with the response.
      lat = 2;
      wait_accept("acc_coinc_a");
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      check("coinc_kill", 32'(dut.kill), 0);
      check("coinc_valid", 32'(inst_valid), 0);
      wait_accept("acc_coinc_b");
      check("coinc_target", acc_addr, 32'h0000_0200);
      lat = 1;
      // PC wrap.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      wait_accept("acc_wrap_a");
      check("wrap_a", acc_addr, 32'hFFFF_FFFC);
      wait_accept("acc_wrap_b");
      check("wrap_b", acc_addr, 32'h0000_0000);
      d0 = delivered;
      wait_deliv("deliv_wrap", d0 + 1);
      // Misaligned redirect.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
      check("fault", 32'(fetch_fault), 1);
      check("fault_req", 32'(imem_req), 0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      step();
      redirect = 1'b0;
      repeat (4) begin
         step();
         check("parked_req_drv", 32'(imem_req), 0);
      end
      check("fault_sticky", 32'(fetch_fault), 1);
`else
      wait_accept("acc_align");
      check("align_target", acc_addr, 32'h0000_0100);
      d0 = delivered;
      wait_deliv("deliv_align", d0 + 1);
`endif
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
